alarm_clock_ctrl: RTL



---
 rtl/alarm_clock_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/alarm_clock_ctrl.sv
// HH:MM alarm clock mode controller: time/alarm registers, set modes and ring sequencing.
// Optional snooze support is compiled in with `define ALARM_SNOOZE_EN.
module alarm_clock_ctrl #(
  parameter int unsigned RING_MIN   = 1,
  parameter int unsigned SNOOZE_MIN = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       ack_btn,
  input  logic       alarm_en,
  input  logic       snooze_btn,
  output logic [2:0] hour_tens,
  output logic [3:0] hour_units,
  output logic [2:0] min_tens,
  output logic [3:0] min_units,
  output logic [2:0] mode,
  output logic       ring,
  output logic       edit_hr,
  output logic       edit_min
);

  localparam int unsigned HW = 7;  // {tens[2:0], units[3:0]} BCD field
  localparam int unsigned RW = 4;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    SET_HR  = 3'd1,
    SET_MIN = 3'd2,
    ALM_HR  = 3'd3,
    ALM_MIN = 3'd4,
    RINGING = 3'd5,
    SNOOZE  = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] t_hr_q, t_hr_d, t_mn_q, t_mn_d;
  logic [HW-1:0] a_hr_q, a_hr_d, a_mn_q, a_mn_d;
  logic [HW-1:0] disp_hr_q, disp_hr_d, disp_mn_q, disp_mn_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic          ring_q, ring_d;
  logic          edit_hr_q, edit_hr_d;
  logic          edit_min_q, edit_min_d;

`ifdef ALARM_SNOOZE_EN
  localparam int unsigned SW = 8;
  logic [SW-1:0] snooze_cnt_q, snooze_cnt_d;
`else
  logic snooze_unused;
  assign snooze_unused = snooze_btn ^ (SNOOZE_MIN == 0);
`endif

  // BCD hour increment, wraps 23 -> 00
  function automatic logic [HW-1:0] hr_inc(input logic [HW-1:0] h);
    if (h[6:4] == 3'd2 && h[3:0] == 4'd3) return HW'(0);
    if (h[3:0] == 4'd9) return {3'(h[6:4] + 3'd1), 4'd0};
    return {h[6:4], 4'(h[3:0] + 4'd1)};
  endfunction

  // BCD minute increment; MSB of the result is the carry into the hour
  function automatic logic [HW:0] min_inc(input logic [HW-1:0] m);
    if (m[3:0] != 4'd9) return {1'b0, m[6:4], 4'(m[3:0] + 4'd1)};
    if (m[6:4] == 3'd5) return {1'b1, 7'd0};
    return {1'b0, 3'(m[6:4] + 3'd1), 4'd0};
  endfunction

  logic [HW:0]   mn_nx;
  logic [HW-1:0] hr_nx;
  logic          adv, inc, exit_ring, alm_view;

  always_comb begin
    state_d    = state_q;
    t_hr_d     = t_hr_q;
    t_mn_d     = t_mn_q;
    a_hr_d     = a_hr_q;
    a_mn_d     = a_mn_q;
    ring_cnt_d = ring_cnt_q;
    ring_d     = ring_q;
`ifdef ALARM_SNOOZE_EN
    snooze_cnt_d = snooze_cnt_q;
`endif

    mn_nx     = min_inc(t_mn_q);
    hr_nx     = mn_nx[HW] ? hr_inc(t_hr_q) : t_hr_q;
    adv       = tick && (state_q != SET_HR) && (state_q != SET_MIN);
    inc       = inc_btn && !mode_btn;
    exit_ring = ack_btn || mode_btn || !alarm_en;

    if (adv) begin
      t_hr_d = hr_nx;
      t_mn_d = mn_nx[HW-1:0];
    end

    case (state_q)
      RUN: begin
        if (mode_btn) begin
          state_d = SET_HR;
        end else if (tick && alarm_en && {hr_nx, mn_nx[HW-1:0]} == {a_hr_q, a_mn_q}) begin
          state_d    = RINGING;
          ring_d     = 1'b1;
          ring_cnt_d = RW'(RING_MIN);
        end
      end
      SET_HR: begin
        if (inc) t_hr_d = hr_inc(t_hr_q);
        if (mode_btn) state_d = SET_MIN;
      end
      SET_MIN: begin
        if (inc) t_mn_d = mn_nx[HW-1:0];
        if (mode_btn) state_d = ALM_HR;
      end
      ALM_HR: begin
        if (inc) a_hr_d = hr_inc(a_hr_q);
        if (mode_btn) state_d = ALM_MIN;
      end
      ALM_MIN: begin
        if (inc) a_mn_d = min_inc(a_mn_q)[HW-1:0];
        if (mode_btn) state_d = RUN;
      end
      RINGING: begin
        if (exit_ring) begin
          state_d = RUN;
          ring_d  = 1'b0;
`ifdef ALARM_SNOOZE_EN
        end else if (snooze_btn) begin
          state_d      = SNOOZE;
          ring_d       = 1'b0;
          snooze_cnt_d = SW'(SNOOZE_MIN);
`endif
        end else if (tick) begin
          if (ring_cnt_q <= RW'(1)) begin
            state_d    = RUN;
            ring_d     = 1'b0;
            ring_cnt_d = '0;
          end else begin
            ring_cnt_d = ring_cnt_q - RW'(1);
          end
        end
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        if (exit_ring) begin
          state_d = RUN;
        end else if (tick) begin
          if (snooze_cnt_q <= SW'(1)) begin
            state_d      = RINGING;
            ring_d       = 1'b1;
            ring_cnt_d   = RW'(RING_MIN);
            snooze_cnt_d = '0;
          end else begin
            snooze_cnt_d = snooze_cnt_q - SW'(1);
          end
        end
      end
`endif
      default: begin
        state_d = RUN;
        ring_d  = 1'b0;
      end
    endcase

    // Display and edit hints follow the next state so they change with mode
    alm_view   = (state_d == ALM_HR) || (state_d == ALM_MIN);
    edit_hr_d  = (state_d == SET_HR) || (state_d == ALM_HR);
    edit_min_d = (state_d == SET_MIN) || (state_d == ALM_MIN);
    disp_hr_d  = alm_view ? a_hr_d : t_hr_d;
    disp_mn_d  = alm_view ? a_mn_d : t_mn_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      t_hr_q     <= '0;
      t_mn_q     <= '0;
      a_hr_q     <= '0;
      a_mn_q     <= '0;
      disp_hr_q  <= '0;
      disp_mn_q  <= '0;
      ring_cnt_q <= '0;
      ring_q     <= 1'b0;
      edit_hr_q  <= 1'b0;
      edit_min_q <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snooze_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      t_hr_q     <= t_hr_d;
      t_mn_q     <= t_mn_d;
      a_hr_q     <= a_hr_d;
      a_mn_q     <= a_mn_d;
      disp_hr_q  <= disp_hr_d;
      disp_mn_q  <= disp_mn_d;
      ring_cnt_q <= ring_cnt_d;
      ring_q     <= ring_d;
      edit_hr_q  <= edit_hr_d;
      edit_min_q <= edit_min_d;
`ifdef ALARM_SNOOZE_EN
      snooze_cnt_q <= snooze_cnt_d;
`endif
    end
  end

  assign hour_tens  = disp_hr_q[6:4];
  assign hour_units = disp_hr_q[3:0];
  assign min_tens   = disp_mn_q[6:4];
  assign min_units  = disp_mn_q[3:0];
  assign mode       = state_q;
  assign ring       = ring_q;
  assign edit_hr    = edit_hr_q;
  assign edit_min   = edit_min_q;

endmodule
